tdes_sequencer: RTL and testbench

Triple-DES EDE controller that sits directly upstream of the 16-round DES core. It accepts a 64-bit block, three 64-bit keys and a mode bit over a valid/ready handshake. It then drives the core through three single-DES passes: encrypt K1, decrypt K2, encrypt K3 for encryption, and the reverse order for decryption. The final block is returned over a second valid/ready handshake, with a per-pass timeout that flags a hung core.

---
 rtl/tdes_sequencer_if.sv | 33 +++
 rtl/tdes_sequencer.sv | 151 +++++++++++++++
 tb/tb_tdes_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tdes_sequencer_if.sv
// Bundle of the request/response handshakes and the DES core connection
// used by the triple-DES EDE sequencer.
interface tdes_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;
    logic        decrypt;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        error;

    logic        des_reset;
    logic [63:0] des_data;
    logic [63:0] des_key;
    logic        des_decrypt;
    logic        des_done;
    logic [63:0] des_result;

    modport master (
        output in_valid, in_data, key1, key2, key3, decrypt, out_ready, des_done, des_result,
        input  in_ready, out_valid, out_data, error, des_reset, des_data, des_key, des_decrypt
    );

    modport slave (
        input  in_valid, in_data, key1, key2, key3, decrypt, out_ready, des_done, des_result,
        output in_ready, out_valid, out_data, error, des_reset, des_data, des_key, des_decrypt
    );
endinterface

// File: rtl/tdes_sequencer.sv
// Triple-DES EDE/DED controller: drives a single-DES core through three
// chained passes and returns the final block, with a per-pass hang timeout.
module tdes_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    tdes_sequencer_if.slave  bus
);
    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_OUT
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    pass_q, pass_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   work_q, work_d;
    logic [63:0]   k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic          mode_q, mode_d;
    logic          err_q, err_d;
    logic [64:0]   sel_d;

    logic          in_ready_q;
    logic          out_valid_q;
    logic          des_reset_q;
    logic [63:0]   des_key_q;
    logic          des_decrypt_q;

    // Key and direction for a pass: EDE uses k1,k2,k3 / DED uses k3,k2,k1.
    function automatic logic [64:0] pass_sel(input logic [1:0] p, input logic dec,
                                             input logic [63:0] k1, input logic [63:0] k2,
                                             input logic [63:0] k3);
        logic [63:0] k;
        if (p == 2'd1)
            k = k2;
        else if ((p == 2'd0) != dec)
            k = k1;
        else
            k = k3;
        return {dec ^ (p == 2'd1), k};
    endfunction

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
        mode_d  = mode_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    work_d  = bus.in_data;
                    k1_d    = bus.key1;
                    k2_d    = bus.key2;
                    k3_d    = bus.key3;
                    mode_d  = bus.decrypt;
                    pass_d  = 2'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.des_done) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    work_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_CAPTURE: begin
                // Core output register lags done by one cycle, so take it here.
                work_d = bus.des_result;
                if (pass_q != 2'd2) begin
                    pass_d  = pass_q + 2'd1;
                    state_d = S_START;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        sel_d = pass_sel(pass_d, mode_d, k1_d, k2_d, k3_d);
    end

    // All outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pass_q        <= 2'd0;
            cnt_q         <= '0;
            work_q        <= '0;
            k1_q          <= '0;
            k2_q          <= '0;
            k3_q          <= '0;
            mode_q        <= 1'b0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            des_reset_q   <= 1'b1;
            des_key_q     <= '0;
            des_decrypt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pass_q        <= pass_d;
            cnt_q         <= cnt_d;
            work_q        <= work_d;
            k1_q          <= k1_d;
            k2_q          <= k2_d;
            k3_q          <= k3_d;
            mode_q        <= mode_d;
            err_q         <= err_d;
            in_ready_q    <= (state_d == S_IDLE);
            out_valid_q   <= (state_d == S_OUT);
            des_reset_q   <= (state_d == S_START);
            des_key_q     <= sel_d[63:0];
            des_decrypt_q <= sel_d[64];
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = work_q;
    assign bus.error       = err_q;
    assign bus.des_reset   = des_reset_q;
    assign bus.des_data    = work_q;
    assign bus.des_key     = des_key_q;
    assign bus.des_decrypt = des_decrypt_q;
endmodule

// File: tb/tb_tdes_sequencer.sv
// Directed bench for tdes_sequencer with a behavioural DES core model and a
// result scoreboard.
module tb_tdes_sequencer;
    localparam int unsigned TIMEOUT = 255;
    localparam logic [63:0] KAT_KEY = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] KAT_PT  = 64'h4E6F_7720_6973_2074;
    localparam logic [63:0] KAT_CT  = 64'h3FA4_0E8A_984D_4815;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tdes_sequencer_if bus ();
    tdes_sequencer #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Core model: done in WAIT cycle core_lat, result register one cycle later.
    int          core_lat  = 5;
    bit          core_hang = 1'b0;
    bit          core_kat  = 1'b0;
    int          core_cnt  = 0;
    logic [63:0] core_res  = '0;

    function automatic logic [63:0] core_f(input logic [63:0] d, input logic [63:0] k, input logic dec);
        if (core_kat) begin
            if (k == KAT_KEY && !dec && d == KAT_PT) return KAT_CT;
            if (k == KAT_KEY &&  dec && d == KAT_CT) return KAT_PT;
            return 64'hBAD0_BAD0_BAD0_BAD0;
        end
        return d ^ k;
    endfunction

    always @(posedge clk) begin
        if (bus.des_reset) core_cnt <= 0;
        else               core_cnt <= core_cnt + 1;
        if (bus.des_done)  core_res <= core_f(bus.des_data, bus.des_key, bus.des_decrypt);
    end
    assign bus.des_done   = !bus.des_reset && !core_hang && (core_cnt == core_lat - 1);
    assign bus.des_result = core_res;

    int total  = 0;
    int passes = 0;
    int fails  = 0;
    logic [64:0] sb_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request; returns just after the accepting edge.
    task automatic send(input logic [63:0] d, input logic dec, input logic [63:0] k1,
                        input logic [63:0] k2, input logic [63:0] k3, output bit ok);
        bus.in_data  = d;
        bus.key1     = k1;
        bus.key2     = k2;
        bus.key3     = k3;
        bus.decrypt  = dec;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.in_ready;
            tick();
        end
    endtask

    task automatic txn(input logic [63:0] d, input logic dec, input logic [63:0] k1,
                       input logic [63:0] k2, input logic [63:0] k3,
                       input logic [63:0] exp_out, input logic exp_err, input int exp_lat,
                       input int exp_pulses, input bit chk_keys, input bit chk_data,
                       input int hold);
        logic [63:0] ek [3];
        logic        ed [3];
        logic [63:0] gk [3];
        logic        gd [3];
        logic [63:0] gdat [3];
        logic [63:0] edat;
        logic [64:0] sb;
        int n, pulses;
        bit ok, busy_ready, key_moved, unstable;

        if (dec) begin ek = '{k3, k2, k1}; ed = '{1'b1, 1'b0, 1'b1}; end
        else     begin ek = '{k1, k2, k3}; ed = '{1'b0, 1'b1, 1'b0}; end
        gk = '{64'd0, 64'd0, 64'd0}; gd = '{1'b0, 1'b0, 1'b0}; gdat = '{64'd0, 64'd0, 64'd0};

        sb_q.push_back({exp_err, exp_out});
        send(d, dec, k1, k2, k3, ok);
        chk("accept", 64'(ok), 64'd1);
        // Scramble inputs to show they are latched at accept.
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        bus.key1     = ~k1;
        bus.key2     = ~k2;
        bus.key3     = ~k3;
        bus.decrypt  = ~dec;

        n = 0; pulses = 0; busy_ready = 1'b0; key_moved = 1'b0;
        while (!bus.out_valid && n < 2000) begin
            if (bus.des_reset) begin
                if (pulses < 3) begin
                    gk[pulses] = bus.des_key; gd[pulses] = bus.des_decrypt; gdat[pulses] = bus.des_data;
                end
                pulses++;
            end else if (pulses > 0 && pulses <= 3) begin
                if (bus.des_key !== gk[pulses-1] || bus.des_decrypt !== gd[pulses-1]) key_moved = 1'b1;
            end
            if (bus.in_ready) busy_ready = 1'b1;
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(exp_lat));
        chk("des_reset_pulses", 64'(pulses), 64'(exp_pulses));
        chk("in_ready_busy", 64'(busy_ready), 64'd0);
        chk("key_hold", 64'(key_moved), 64'd0);
        if (chk_keys) begin
            edat = d;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("pass%0d_key", p), gk[p], ek[p]);
                chk($sformatf("pass%0d_dec", p), 64'(gd[p]), 64'(ed[p]));
                if (chk_data) chk($sformatf("pass%0d_data", p), gdat[p], edat);
                edat = edat ^ ek[p];
            end
        end

        sb = sb_q.pop_front();
        chk("out_valid", 64'(bus.out_valid), 64'd1);
        chk("out_data", bus.out_data, sb[63:0]);
        chk("error", 64'(bus.error), 64'(sb[64]));

        unstable = 1'b0;
        if (hold > 0) bus.in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (bus.out_data !== sb[63:0] || bus.error !== sb[64] ||
                bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) unstable = 1'b1;
        end
        if (hold > 0) chk("hold_stable", 64'(unstable), 64'd0);

        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_hs_no_accept", 64'(bus.des_reset), 64'd0);
    endtask

    initial begin : stim
        logic [63:0] d, k1, k2, k3;
        logic        dec;
        bit          ok;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.key1      = '0;
        bus.key2      = '0;
        bus.key3      = '0;
        bus.decrypt   = 1'b0;
        bus.out_ready = 1'b0;

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_error", 64'(bus.error), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_des_reset", 64'(bus.des_reset), 64'd1);
        chk("rst_des_data", bus.des_data, 64'd0);
        chk("rst_des_key", bus.des_key, 64'd0);
        chk("rst_des_decrypt", 64'(bus.des_decrypt), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_des_reset", 64'(bus.des_reset), 64'd0);

        // Known-answer vectors with identical keys, 16-cycle core.
        core_kat = 1'b1; core_lat = 16;
        txn(KAT_PT, 1'b0, KAT_KEY, KAT_KEY, KAT_KEY, KAT_CT, 1'b0, 54, 3, 1'b1, 1'b0, 0);
        txn(KAT_CT, 1'b1, KAT_KEY, KAT_KEY, KAT_KEY, KAT_PT, 1'b0, 54, 3, 1'b1, 1'b0, 0);

        // XOR stub, W=5, distinct keys, both modes.
        core_kat = 1'b0; core_lat = 5;
        k1 = 64'h1111_2222_3333_4444; k2 = 64'h0F0F_0F0F_5555_AAAA; k3 = 64'hC3C3_1234_FEDC_0001;
        d  = 64'hA5A5_5A5A_0123_4567;
        txn(d, 1'b0, k1, k2, k3, d ^ k1 ^ k2 ^ k3, 1'b0, 21, 3, 1'b1, 1'b1, 0);
        txn(d, 1'b1, k1, k2, k3, d ^ k1 ^ k2 ^ k3, 1'b0, 21, 3, 1'b1, 1'b1, 10);
        // A request is already pending from the hold window above.
        txn(~d, 1'b0, k3, k1, k2, ~d ^ k1 ^ k2 ^ k3, 1'b0, 21, 3, 1'b1, 1'b1, 0);

        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom}; k1 = {$urandom, $urandom};
            k2 = {$urandom, $urandom}; k3 = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            txn(d, dec, k1, k2, k3, d ^ k1 ^ k2 ^ k3, 1'b0, 21, 3, 1'b1, 1'b1, 0);
        end

        // Hung core: abort after the timeout, then recover.
        core_hang = 1'b1;
        txn(d, 1'b0, k1, k2, k3, 64'd0, 1'b1, int'(TIMEOUT) + 2, 1, 1'b0, 1'b0, 0);
        core_hang = 1'b0;
        txn(d, 1'b1, k1, k2, k3, d ^ k1 ^ k2 ^ k3, 1'b0, 21, 3, 1'b1, 1'b1, 0);

        // Reset in the second WAIT cycle of pass1.
        send(d, 1'b0, k1, k2, k3, ok);
        chk("rst_mid_accept", 64'(ok), 64'd1);
        bus.in_valid = 1'b0;
        repeat (9) tick();
        chk("rst_mid_pre_des_reset", 64'(bus.des_reset), 64'd0);
        chk("rst_mid_pre_in_ready", 64'(bus.in_ready), 64'd0);
        reset = 1'b1;
        tick();
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_des_reset", 64'(bus.des_reset), 64'd1);
        tick();
        chk("rst_mid_des_reset_held", 64'(bus.des_reset), 64'd1);
        reset = 1'b0;
        tick();
        chk("rst_mid_release_des_reset", 64'(bus.des_reset), 64'd0);
        chk("rst_mid_release_out_valid", 64'(bus.out_valid), 64'd0);
        k1 = 64'h0123_0000_FFFF_1357; k2 = 64'h8000_0000_0000_0001; k3 = 64'h7E7E_7E7E_8181_8181;
        d  = 64'hDEAD_BEEF_CAFE_F00D;
        txn(d, 1'b0, k1, k2, k3, d ^ k1 ^ k2 ^ k3, 1'b0, 21, 3, 1'b1, 1'b1, 0);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
